// File: rtl/axis_pkt_mux_pkg.sv
// Shared types and defaults for the AXI-Stream packet multiplexer.
package axis_pkt_mux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer; in_ready depends only on occupancy, never on out_ready.
module axis_skid_buf #(
  parameter int W = 9
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Head entry is only rewritten after it pops, so it stays stable under backpressure.
  assign out_data  = mem[rptr];

  always_ff @(posedge aclk) begin
    if (areset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/axis_pkt_mux.sv
// Packet-locked AXI-Stream N:1 mux. Fixed-select arbitration by default;
// define AXIS_PKT_MUX_RR_EN for round-robin arbitration (sel then unused).
module axis_pkt_mux
  import axis_pkt_mux_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  NUM_CH = NUM_CH_DEF,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     busy
);

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ch_q;
  logic [SEL_W-1:0]   grant_ch;
  logic               grant_vld;
  logic               cur_vld;
  logic               cur_last;
  logic [DATA_W-1:0]  cur_data;
  logic               beat_ok;
  logic               buf_in_ready;
  logic               buf_out_valid;
  logic [DATA_W:0]    buf_out;

  assign cur_vld  = s_axis_tvalid[ch_q];
  assign cur_last = s_axis_tlast[ch_q];
  assign cur_data = s_axis_tdata[ch_q*DATA_W +: DATA_W];
  assign beat_ok  = !areset && (state == LOCKED) && cur_vld && buf_in_ready;

`ifdef AXIS_PKT_MUX_RR_EN
  logic [SEL_W-1:0] rr_last;
  logic             unused_sel;
  int               idx;

  assign unused_sel = ^sel;

  // Search starts one past the previous grant, wrapping at NUM_CH.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_last) + k) % NUM_CH;
      if (!grant_vld && s_axis_tvalid[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = SEL_W'(idx);
      end
    end
  end

  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge aclk) begin
    if (areset)                           rr_last <= SEL_W'(NUM_CH - 1);
    else if (state == IDLE && grant_vld)  rr_last <= grant_ch;
  end
`else
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = sel;
    if ({1'b0, sel} < NUM_CH_L) grant_vld = s_axis_tvalid[sel];
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = LOCKED;
      LOCKED:  if (beat_ok && cur_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset)                          ch_q <= '0;
    else if (state == IDLE && grant_vld) ch_q <= grant_ch;
  end

  always_comb begin
    s_axis_tready = '0;
    if (!areset && state == LOCKED) s_axis_tready[ch_q] = buf_in_ready;
  end

  axis_skid_buf #(
    .W(DATA_W + 1)
  ) u_buf (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   ({cur_last, cur_data}),
    .in_valid  (beat_ok),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (buf_out_valid),
    .out_ready (m_axis_tready)
  );

  // Outputs are masked while reset is held, not just after the first reset edge.
  assign m_axis_tvalid = buf_out_valid && !areset;
  assign m_axis_tlast  = buf_out[DATA_W] && !areset;
  assign m_axis_tdata  = areset ? '0 : buf_out[DATA_W-1:0];
  assign active_ch     = areset ? '0 : ch_q;
  assign busy          = (state == LOCKED) && !areset;

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Randomised + directed bench for axis_pkt_mux with a queue-based reference model.
module tb_axis_pkt_mux;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SW = 2;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [NC*DW-1:0] s_axis_tdata = '0;
  logic [NC-1:0]    s_axis_tvalid = '0;
  logic [NC-1:0]    s_axis_tlast = '0;
  logic [NC-1:0]    s_axis_tready;
  logic [SW-1:0]    sel = '0;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b1;
  logic [SW-1:0]    active_ch;
  logic             busy;

  axis_pkt_mux #(.DATA_W(DW), .NUM_CH(NC)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .sel(sel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .active_ch(active_ch), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; logic l; int c; } out_t;

  beat_t src_q [NC][$];
  beat_t mq[$];
  out_t  out_log[$];
  int    grant_log[$];

  int checks = 0, failures = 0, cyc = 0;
  int stall = 0;
  bit rand_rdy = 0;
  logic [NC-1:0] hs;

  bit    mlock = 0;
  int    mch = 0, rr_last = NC - 1, idx = 0;
  bit    e_vld, acc, prev_busy = 0, prev_stall = 0;
  logic [NC-1:0] e_rdy;
  logic [DW-1:0] prev_data = '0;
  beat_t b;
  int rdy0_first = -1, rdy2_low = 0, hold_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i*DW +: DW] = src_q[i][0].d;
        s_axis_tlast[i] = src_q[i][0].l;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tlast[i] = 1'b0;
      end
    end
  endtask

  // Source driver and sink ready generator.
  initial begin
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NC; i++)
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive();
      if (stall > 0) begin
        m_axis_tready = 1'b0;
        stall--;
      end else begin
        m_axis_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Reference model and per-cycle compare.
  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_active_ch", active_ch, 0);
      mq.delete();
      mlock = 0;
      mch = 0;
      rr_last = NC - 1;
      prev_stall = 0;
    end else begin
      e_vld = (mq.size() > 0);
      chk("m_tvalid", m_axis_tvalid, e_vld);
      if (e_vld) begin
        chk("m_tdata", m_axis_tdata, mq[0].d);
        chk("m_tlast", m_axis_tlast, mq[0].l);
      end
      e_rdy = '0;
      if (mlock && mq.size() < 2) e_rdy[mch] = 1'b1;
      chk("s_tready", s_axis_tready, e_rdy);
      chk("busy", busy, mlock);
      chk("active_ch", active_ch, mch);

      if (m_axis_tvalid && m_axis_tready) out_log.push_back('{m_axis_tdata, m_axis_tlast, cyc});
      if (busy && !prev_busy) grant_log.push_back(int'(active_ch));
      if (s_axis_tready[0] && rdy0_first < 0) rdy0_first = cyc;
      if (busy && active_ch == 2 && !s_axis_tready[2]) rdy2_low++;
      if (prev_stall && m_axis_tvalid && m_axis_tdata != prev_data) hold_bad++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;

      acc = mlock && s_axis_tvalid[mch] && (mq.size() < 2);
      if (acc) begin
        b.d = s_axis_tdata[mch*DW +: DW];
        b.l = s_axis_tlast[mch];
      end
      if (e_vld && m_axis_tready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(b);
        if (b.l) mlock = 0;
      end else if (!mlock) begin
`ifdef AXIS_PKT_MUX_RR_EN
        for (int k = 1; k <= NC; k++) begin
          idx = (rr_last + k) % NC;
          if (!mlock && s_axis_tvalid[idx]) begin
            mlock = 1;
            mch = idx;
            rr_last = idx;
          end
        end
`else
        if (s_axis_tvalid[sel]) begin
          mlock = 1;
          mch = int'(sel);
        end
`endif
      end
    end
    prev_busy = busy;
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic push_pkt(input int ch, input logic [DW-1:0] base, input int len, input bit rnd);
    beat_t x;
    for (int i = 0; i < len; i++) begin
      x.d = rnd ? DW'($urandom) : base + DW'(i);
      x.l = (i == len - 1);
      src_q[ch].push_back(x);
    end
  endtask

  task automatic flush_src();
    for (int i = 0; i < NC; i++) src_q[i].delete();
    drive();
  endtask

  function automatic bit any_src();
    for (int i = 0; i < NC; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((any_src() || mq.size() > 0 || mlock) && n < 3000) begin
`ifndef AXIS_PKT_MUX_RR_EN
      if (!mlock)
        for (int i = 0; i < NC; i++) if (src_q[i].size() > 0) sel = SW'(i);
`endif
      step(1);
      n++;
    end
    chk({nm, "_timeout"}, (n < 3000), 1);
    step(2);
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    flush_src();
    step(n);
    areset = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input logic [DW-1:0] base, input int len, input int gap);
    chk({nm, "_count"}, out_log.size(), len);
    for (int i = 0; i < len && i < out_log.size(); i++) begin
      chk({nm, "_data"}, out_log[i].d, base + DW'(i));
      chk({nm, "_last"}, out_log[i].l, (i == len - 1));
      if (gap > 0 && i > 0) chk({nm, "_gap"}, out_log[i].c - out_log[i-1].c, gap);
    end
  endtask

  initial begin
    int n;
    int rand_beats;
    // Reset held two cycles with every channel presenting valid.
    for (int i = 0; i < NC; i++) push_pkt(i, 8'hF0 + DW'(i), 1, 0);
    drive();
    repeat (2) begin
      @(negedge aclk);
      #1;
      chk("r036_s_tvalid_in", s_axis_tvalid, 4'b1111);
      chk("r036_m_tvalid", m_axis_tvalid, 0);
      chk("r036_s_tready", s_axis_tready, 0);
      chk("r036_busy", busy, 0);
    end
    @(posedge aclk);
    #2;
    flush_src();
    areset = 1'b0;
    step(2);

    // Fixed select on ch2, sel moved to 0 mid-packet.
    sel = 2'd2;
    out_log.delete();
    rdy0_first = -1;
    push_pkt(2, 8'h10, 4, 0);
`ifndef AXIS_PKT_MUX_RR_EN
    push_pkt(0, 8'h50, 2, 0);
`endif
    n = 0;
    while (src_q[2].size() > 2 && n < 100) begin step(1); n++; end
    chk("r037_wait", (n < 100), 1);
    sel = 2'd0;
    wait_drain("r037");
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      chk("r037_data", out_log[i].d, 8'h10 + DW'(i));
      chk("r037_last", out_log[i].l, (i == 3));
      if (i > 0) chk("r037_gap", out_log[i].c - out_log[i-1].c, 1);
    end
    chk("r037_ch0_not_ready", (out_log.size() >= 4) && (rdy0_first < 0 || rdy0_first > out_log[3].c), 1);

    // Downstream stall mid-packet.
    sel = 2'd2;
    out_log.delete();
    rdy2_low = 0;
    hold_bad = 0;
    push_pkt(2, 8'h20, 6, 0);
    n = 0;
    while (out_log.size() < 1 && n < 100) begin step(1); n++; end
    stall = 3;
    wait_drain("r038");
    chk_seq("r038", 8'h20, 6, 0);
    chk("r038_ready_dropped", (rdy2_low > 0), 1);
    chk("r038_hold", hold_bad, 0);

    // Reset mid-packet, then a clean packet.
    sel = 2'd2;
    push_pkt(2, 8'h40, 4, 0);
    n = 0;
    while (src_q[2].size() > 2 && n < 100) begin step(1); n++; end
    areset = 1'b1;
    flush_src();
    step(1);
    areset = 1'b0;
    @(negedge aclk);
    chk("r040_flushed", m_axis_tvalid, 0);
    step(1);
    out_log.delete();
    push_pkt(2, 8'hA0, 2, 0);
    wait_drain("r040");
    chk_seq("r040", 8'hA0, 2, 0);

    // Back-to-back single-beat packets on ch1.
    sel = 2'd1;
    out_log.delete();
    for (int i = 0; i < 4; i++) push_pkt(1, 8'h31 + DW'(i), 1, 0);
    wait_drain("r041");
    chk("r041_count", out_log.size(), 4);
    for (int i = 0; i < out_log.size(); i++) begin
      chk("r041_data", out_log[i].d, 8'h31 + DW'(i));
      chk("r041_last", out_log[i].l, 1);
      if (i > 0) chk("r041_gap", out_log[i].c - out_log[i-1].c, 2);
    end

`ifdef AXIS_PKT_MUX_RR_EN
    // Round-robin order from a fresh pointer.
    do_reset(2);
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 8'h00 + DW'(r*2), 2, 0);
      push_pkt(1, 8'h10 + DW'(r*2), 2, 0);
      push_pkt(3, 8'h30 + DW'(r*2), 2, 0);
    end
    drive();
    wait_drain("r039");
    chk("r039_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("r039_grant", grant_log[i], (i % 3 == 2) ? 3 : (i % 3));
`endif

    // Randomised traffic with random backpressure and sel.
    out_log.delete();
    rand_beats = 0;
    rand_rdy = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(1, 5);
        push_pkt($urandom_range(0, NC-1), '0, n, 1);
        rand_beats += n;
      end
      sel = SW'($urandom_range(0, NC-1));
      step(1);
    end
    wait_drain("rand");
    rand_rdy = 0;
    chk("rand_count", out_log.size(), rand_beats);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
